// File: rtl/me_full_search.sv
// Full-search block motion estimator: streams candidate rows, accumulates SAD per
// candidate and keeps the earliest minimum; done pulses the cycle after the last row.
module me_full_search #(
  parameter  int BLK_DIM      = 16,
  parameter  int SEARCH_RANGE = 16,
  parameter  int PIX_W        = 8,
  localparam int SAD_W        = PIX_W + $clog2(BLK_DIM*BLK_DIM),
  localparam int MV_W         = $clog2(SEARCH_RANGE+1) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     cur_valid,
  input  logic [BLK_DIM*PIX_W-1:0] cur_row,
  input  logic                     ref_valid,
  input  logic [BLK_DIM*PIX_W-1:0] ref_row,
  output logic                     ref_ready,
  output logic                     busy,
  output logic                     done,
  output logic [SAD_W-1:0]         min_sad,
  output logic signed [MV_W-1:0]   mv_x,
  output logic signed [MV_W-1:0]   mv_y
);

  localparam int RW    = $clog2(BLK_DIM);
  localparam int ROW_W = BLK_DIM*PIX_W;
  localparam logic [RW-1:0]          ROW_LAST = RW'(BLK_DIM-1);
  localparam logic signed [MV_W-1:0] MV_LO    = MV_W'(-SEARCH_RANGE);
  localparam logic signed [MV_W-1:0] MV_HI    = MV_W'(SEARCH_RANGE);

  typedef enum logic [1:0] {IDLE, LOAD_CUR, SEARCH, DONE} state_t;

  state_t                  state_q;
  logic [RW-1:0]           row_q;
  logic signed [MV_W-1:0]  cx_q, cy_q;
  logic [SAD_W-1:0]        acc_q, acc_d;
  logic [SAD_W-1:0]        min_q;
  logic signed [MV_W-1:0]  mvx_q, mvy_q;
  logic                    done_q;
  logic [ROW_W-1:0]        cur_mem_q [BLK_DIM];
  logic [ROW_W-1:0]        cur_sel;
  logic [SAD_W-1:0]        row_sad;
  logic                    first_cand;

  // Current block is only written while loading; no reset needed on the storage.
  always_ff @(posedge clk) begin
    if (state_q == LOAD_CUR && cur_valid) begin
      cur_mem_q[row_q] <= cur_row;
    end
  end

  always_comb begin
    cur_sel = cur_mem_q[row_q];
    row_sad = '0;
    for (int i = 0; i < BLK_DIM; i++) begin
      if (cur_sel[i*PIX_W +: PIX_W] > ref_row[i*PIX_W +: PIX_W])
        row_sad = row_sad + SAD_W'(cur_sel[i*PIX_W +: PIX_W] - ref_row[i*PIX_W +: PIX_W]);
      else
        row_sad = row_sad + SAD_W'(ref_row[i*PIX_W +: PIX_W] - cur_sel[i*PIX_W +: PIX_W]);
    end
    acc_d      = acc_q + row_sad;
    first_cand = (cx_q == MV_LO) && (cy_q == MV_LO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      acc_q   <= '0;
      min_q   <= '0;
      mvx_q   <= '0;
      mvy_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD_CUR;
            row_q   <= '0;
          end
        end
        LOAD_CUR: begin
          if (cur_valid) begin
            row_q <= row_q + RW'(1);
            if (row_q == ROW_LAST) begin
              state_q <= SEARCH;
              row_q   <= '0;
              cx_q    <= MV_LO;
              cy_q    <= MV_LO;
              acc_q   <= '0;
            end
          end
        end
        SEARCH: begin
          if (ref_valid) begin
            if (row_q != ROW_LAST) begin
              row_q <= row_q + RW'(1);
              acc_q <= acc_d;
            end else begin
              row_q <= '0;
              acc_q <= '0;
              // Strict less-than keeps the earliest candidate on ties.
              if (first_cand || acc_d < min_q) begin
                min_q <= acc_d;
                mvx_q <= cx_q;
                mvy_q <= cy_q;
              end
              if (cx_q == MV_HI) begin
                cx_q <= MV_LO;
                if (cy_q == MV_HI) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                end else begin
                  cy_q <= cy_q + MV_W'(1);
                end
              end else begin
                cx_q <= cx_q + MV_W'(1);
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ref_ready = (state_q == SEARCH);
  assign busy      = (state_q == LOAD_CUR) || (state_q == SEARCH);
  assign done      = done_q;
  assign min_sad   = min_q;
  assign mv_x      = mvx_q;
  assign mv_y      = mvy_q;

endmodule

// File: tb/tb_me_full_search.sv
// Directed bench for me_full_search: 4x4/range-1 instance for most scenarios plus a
// 16x16 instance for the worst-case SAD width.
module tb_me_full_search;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, cur_valid, ref_valid;
  logic [31:0] cur_row, ref_row;
  logic        ref_ready, busy, done;
  logic [11:0] min_sad;
  logic [1:0]  mv_x, mv_y;

  logic         start16, cur_valid16, ref_valid16;
  logic [127:0] cur_row16, ref_row16;
  logic         ref_ready16, busy16, done16;
  logic [15:0]  min_sad16;
  logic [1:0]   mv_x16, mv_y16;

  always #5 clk = ~clk;

  me_full_search #(.BLK_DIM(4), .SEARCH_RANGE(1), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cur_valid(cur_valid), .cur_row(cur_row),
    .ref_valid(ref_valid), .ref_row(ref_row), .ref_ready(ref_ready), .busy(busy),
    .done(done), .min_sad(min_sad), .mv_x(mv_x), .mv_y(mv_y)
  );

  me_full_search #(.BLK_DIM(16), .SEARCH_RANGE(1), .PIX_W(8)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .cur_valid(cur_valid16), .cur_row(cur_row16),
    .ref_valid(ref_valid16), .ref_row(ref_row16), .ref_ready(ref_ready16), .busy(busy16),
    .done(done16), .min_sad(min_sad16), .mv_x(mv_x16), .mv_y(mv_y16)
  );

  typedef struct {
    logic [15:0] sad;
    logic [1:0]  mx;
    logic [1:0]  my;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  cand_v [9];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_sad = '0;
  logic [1:0]  last_mx = '0, last_my = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: uniform blocks, so SAD = 16 * |cur - cand|; first strict minimum wins.
  task automatic model_push(input logic [7:0] cv);
    exp_t e;
    int   best = -1;
    int   d;
    e.sad = '0; e.mx = '0; e.my = '0;
    for (int k = 0; k < 9; k++) begin
      d = (cv > cand_v[k]) ? int'(cv - cand_v[k]) : int'(cand_v[k] - cv);
      if (best < 0 || 16*d < best) begin
        best  = 16*d;
        e.sad = 16'(best);
        e.mx  = 2'(k % 3 - 1);
        e.my  = 2'(k / 3 - 1);
      end
    end
    sb.push_back(e);
  endtask

  task automatic load_cur(input logic [7:0] cv);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("busy_in_load", busy, 1);
    check("hold_min_sad", min_sad, last_sad);
    check("hold_mv", {mv_y, mv_x}, {last_my, last_mx});
    for (int r = 0; r < 4; r++) begin
      cur_valid = 1'b1;
      cur_row   = {4{cv}};
      @(posedge clk); #1;
    end
    cur_valid = 1'b0;
    check("ref_ready_search", ref_ready, 1);
  endtask

  task automatic run_search(input logic [7:0] cv, input bit gaps, input bit disturb);
    int   acc = 0, cyc = 0;
    bit   tog = 1'b1, early = 1'b0, v, rdy;
    exp_t e;
    model_push(cv);
    load_cur(cv);
    while (acc < 36 && cyc < 400) begin
      v = gaps ? tog : 1'b1;
      tog = ~tog;
      ref_valid = v;
      ref_row   = v ? {4{cand_v[acc/4]}} : $urandom;
      if (disturb) begin
        start = 1'b1; cur_valid = 1'b1; cur_row = $urandom;
      end
      rdy = ref_ready;
      @(posedge clk); #1;
      cyc++;
      if (v && rdy) acc++;
      if (done && acc < 36) early = 1'b1;
    end
    ref_valid = 1'b0; start = 1'b0; cur_valid = 1'b0;
    check("rows_accepted", acc, 36);
    check("no_early_done", early, 0);
    check("done_after_last_row", done, 1);
    check("busy_in_done", busy, 0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("min_sad", min_sad, e.sad);
      check("mv_x", mv_x, e.mx);
      check("mv_y", mv_y, e.my);
      last_sad = e.sad; last_mx = e.mx; last_my = e.my;
    end
    @(posedge clk); #1;
    check("done_single_cycle", done, 0);
  endtask

  initial begin
    int  acc, cyc;
    bit  seen;
    rst = 1'b1; start = 0; cur_valid = 0; ref_valid = 0; cur_row = '0; ref_row = '0;
    start16 = 0; cur_valid16 = 0; ref_valid16 = 0; cur_row16 = '0; ref_row16 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ref_ready", ref_ready, 0);
    check("rst_min_sad", min_sad, 0);
    check("rst_mv", {mv_y, mv_x}, 0);
    rst = 1'b0;

    // All equal: every SAD is 0, tie keeps candidate (-1,-1).
    cand_v = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
    run_search(8'h10, 1'b0, 1'b0);

    // Nonzero minimum of 16 shared by candidates 6 and 7; earliest wins.
    cand_v = '{8'h50, 8'h45, 8'h3E, 8'h60, 8'h30, 8'h42, 8'h41, 8'h3F, 8'h48};
    run_search(8'h40, 1'b0, 1'b0);

    // Abort mid-search after 10 accepted rows.
    load_cur(8'h00);
    acc = 0;
    while (acc < 10) begin
      ref_valid = 1'b1; ref_row = '0;
      @(posedge clk); #1; acc++;
    end
    ref_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_ref_ready", ref_ready, 0);
    check("abort_min_sad", min_sad, 0);
    check("abort_mv", {mv_y, mv_x}, 0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("abort_no_done", seen, 0);
    last_sad = '0; last_mx = '0; last_my = '0;

    cand_v = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01};
    run_search(8'h00, 1'b0, 1'b0);
    cand_v[8] = 8'h00;
    run_search(8'h00, 1'b0, 1'b0);
    cand_v[8] = 8'h01;
    run_search(8'h00, 1'b1, 1'b0);

    // start/cur_valid stirred throughout SEARCH; exact match at (+1,+1).
    cand_v = '{8'h90, 8'h70, 8'h85, 8'h7C, 8'h81, 8'h7F, 8'hA0, 8'h60, 8'h80};
    run_search(8'h80, 1'b0, 1'b1);

    // Stray ref rows while idle are ignored.
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ref_valid = 1'b1; ref_row = '0;
      if (ref_ready || busy || done) seen = 1'b1;
      @(posedge clk); #1;
    end
    ref_valid = 1'b0;
    check("idle_ignores_ref", seen, 0);
    check("idle_holds_sad", min_sad, last_sad);

    // 16x16 worst case: 256 * 255 = 65280 must not wrap.
    @(posedge clk); #1 start16 = 1'b1;
    @(posedge clk); #1 start16 = 1'b0;
    check("busy16_load", busy16, 1);
    for (int r = 0; r < 16; r++) begin
      cur_valid16 = 1'b1; cur_row16 = {16{8'hFF}};
      @(posedge clk); #1;
    end
    cur_valid16 = 1'b0;
    acc = 0; cyc = 0;
    while (acc < 144 && cyc < 400) begin
      ref_valid16 = 1'b1; ref_row16 = '0;
      seen = ref_ready16;
      @(posedge clk); #1;
      cyc++;
      if (seen) acc++;
    end
    ref_valid16 = 1'b0;
    check("done16", done16, 1);
    check("min_sad16", min_sad16, 16'd65280);
    check("mv16", {mv_y16, mv_x16}, 4'b1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
